// File: rtl/vote_tally.sv
// vote_tally - ballot tally stage behind the combinational voting block.
//
// Takes one G result per valid/ready handshake as a ballot and keeps yes/no
// tallies for a voting session. The session ends after VOTERS ballots or on
// close. The stage then registers a pass/tie verdict for the display stage.
//
// Optional feature: define VOTE_TALLY_TIMEOUT_EN to add parameter TIMEOUT and
// output timed_out. With it, a session that goes TIMEOUT cycles without an
// accept closes on its own.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   start               pulse: open a session (IDLE/DONE only)
//   close               pulse: end collection early (COLLECT only)
//   ballot_valid/_g     upstream ballot handshake and its value (1 = yes)
//   ballot_ready        high while collecting
//   yes_count/no_count  accepted ballots this session
//   busy                COLLECT or DECIDE
//   done                verdict valid (DONE)
//   result_pass/_tie    yes > no / yes == no
//   timed_out           (optional) session was auto-closed by the timeout
module vote_tally #(
    parameter int VOTERS  = 8,
    parameter int CW      = 4
`ifdef VOTE_TALLY_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 16
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          close,
    input  logic          ballot_valid,
    input  logic          ballot_g,
    output logic          ballot_ready,
    output logic [CW-1:0] yes_count,
    output logic [CW-1:0] no_count,
    output logic          busy,
    output logic          done,
    output logic          result_pass,
    output logic          result_tie
`ifdef VOTE_TALLY_TIMEOUT_EN
    ,
    output logic          timed_out
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DECIDE, S_DONE} state_t;

    state_t        r_state, w_next;
    logic [CW-1:0] r_yes, r_no;
    logic          r_pass, r_tie;
    logic          w_accept;
    logic [CW:0]   w_total;
    logic          w_full;
    logic          w_timeout;

    assign w_accept = ballot_valid & ballot_ready;
    // Total including the ballot being accepted this cycle. The extra bit
    // keeps the sum from wrapping.
    assign w_total  = {1'b0, r_yes} + {1'b0, r_no} + {{CW{1'b0}}, w_accept};
    assign w_full   = w_accept && (w_total == (CW+1)'(VOTERS));

`ifdef VOTE_TALLY_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] r_idle;
    logic          r_timed_out;

    // r_idle counts COLLECT cycles since the last accept. The session fires
    // on the TIMEOUT-th such cycle.
    assign w_timeout = (r_state == S_COLLECT) && !w_accept &&
                       (r_idle == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle      <= '0;
            r_timed_out <= 1'b0;
        end else begin
            if (r_state != S_COLLECT || w_accept)
                r_idle <= '0;
            else
                r_idle <= r_idle + TW'(1);
            if ((r_state == S_IDLE || r_state == S_DONE) && start)
                r_timed_out <= 1'b0;
            else if (w_timeout)
                r_timed_out <= 1'b1;
        end
    end

    assign timed_out = r_timed_out;
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next = S_COLLECT;
            S_COLLECT: if (w_full || close || w_timeout) w_next = S_DECIDE;
            S_DECIDE:  w_next = S_DONE;
            S_DONE:    if (start) w_next = S_COLLECT;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_yes  <= '0;
            r_no   <= '0;
            r_pass <= 1'b0;
            r_tie  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_yes <= '0;
                    r_no  <= '0;
                end
                S_COLLECT: if (w_accept) begin
                    if (ballot_g) r_yes <= r_yes + CW'(1);
                    else          r_no  <= r_no + CW'(1);
                end
                S_DECIDE: begin
                    r_pass <= (r_yes > r_no);
                    r_tie  <= (r_yes == r_no);
                end
                S_DONE: if (start) begin
                    r_yes  <= '0;
                    r_no   <= '0;
                    r_pass <= 1'b0;
                    r_tie  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign ballot_ready = (r_state == S_COLLECT);
    assign busy         = (r_state == S_COLLECT) || (r_state == S_DECIDE);
    assign done         = (r_state == S_DONE);
    assign yes_count    = r_yes;
    assign no_count     = r_no;
    assign result_pass  = r_pass;
    assign result_tie   = r_tie;

endmodule

// File: tb/tb_vote_tally.sv
module tb_vote_tally;
    localparam int VOTERS = 8;
    localparam int CW     = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0, close = 1'b0;
    logic          ballot_valid = 1'b0, ballot_g = 1'b0;
    logic          ballot_ready, busy, done, result_pass, result_tie;
    logic [CW-1:0] yes_count, no_count;
`ifdef VOTE_TALLY_TIMEOUT_EN
    logic          timed_out;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    vote_tally #(.VOTERS(VOTERS), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .close(close),
        .ballot_valid(ballot_valid), .ballot_g(ballot_g),
        .ballot_ready(ballot_ready), .yes_count(yes_count), .no_count(no_count),
        .busy(busy), .done(done), .result_pass(result_pass), .result_tie(result_tie)
`ifdef VOTE_TALLY_TIMEOUT_EN
        , .timed_out(timed_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Step one active edge, then sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".ready"}, 8'(ballot_ready), 0);
        chk({tag, ".busy"},  8'(busy), 0);
        chk({tag, ".done"},  8'(done), 0);
        chk({tag, ".pass"},  8'(result_pass), 0);
        chk({tag, ".tie"},   8'(result_tie), 0);
        chk({tag, ".yes"},   8'(yes_count), 0);
        chk({tag, ".no"},    8'(no_count), 0);
`ifdef VOTE_TALLY_TIMEOUT_EN
        chk({tag, ".tmo"},   8'(timed_out), 0);
`endif
    endtask

    // Runs one whole session. Expectations come from counting the ballot
    // bits. n ballots are offered, separated by random gaps. Stray start
    // pulses inside the gaps must be ignored. The session ends on the
    // VOTERS-th ballot, on a close that coincides with the last ballot
    // (cwl), or on a separate close afterwards.
    task automatic session(input string tag, input logic [15:0] bits, input int n, input bit cwl);
        int ey = 0, en = 0;
        bit need_close;
        start = 1'b1; tick(); start = 1'b0;
        chk({tag, ".open_ready"}, 8'(ballot_ready), 1);
        chk({tag, ".open_busy"},  8'(busy), 1);
        chk({tag, ".open_cnt"},   8'({yes_count, no_count}), 0);
        for (int i = 0; i < n; i++) begin
            int gap = $urandom_range(0, 2);
            for (int k = 0; k < gap; k++) begin
                start = ($urandom_range(0, 3) == 0);
                ballot_g = $urandom_range(0, 1);
                tick();
                start = 1'b0;
                chk({tag, ".gap_ready"}, 8'(ballot_ready), 1);
            end
            ballot_valid = 1'b1;
            ballot_g = bits[i];
            close = cwl && (i == n - 1);
            tick();
            ballot_valid = 1'b0;
            close = 1'b0;
            if (bits[i]) ey++; else en++;
            chk({tag, ".yes"}, 8'(yes_count), 8'(ey));
            chk({tag, ".no"},  8'(no_count),  8'(en));
        end
        need_close = (n < VOTERS) && !(cwl && n > 0);
        if (need_close) begin
            close = 1'b1; tick(); close = 1'b0;
        end
        // DECIDE: a ballot offered here must be dropped.
        chk({tag, ".dec_ready"}, 8'(ballot_ready), 0);
        chk({tag, ".dec_busy"},  8'(busy), 1);
        chk({tag, ".dec_done"},  8'(done), 0);
        ballot_valid = 1'b1; ballot_g = 1'b1;
        tick();
        // DONE: a ballot and a close offered here must be ignored.
        close = 1'b1;
        chk({tag, ".done"},  8'(done), 1);
        chk({tag, ".busy"},  8'(busy), 0);
        chk({tag, ".ready"}, 8'(ballot_ready), 0);
        chk({tag, ".pass"},  8'(result_pass), 8'(ey > en));
        chk({tag, ".tie"},   8'(result_tie),  8'(ey == en));
        chk({tag, ".fyes"},  8'(yes_count), 8'(ey));
        chk({tag, ".fno"},   8'(no_count),  8'(en));
`ifdef VOTE_TALLY_TIMEOUT_EN
        chk({tag, ".tmo"},   8'(timed_out), 0);
`endif
        tick();
        ballot_valid = 1'b0; close = 1'b0;
        chk({tag, ".hold_done"}, 8'(done), 1);
        chk({tag, ".hold_cnt"},  8'({yes_count, no_count}), 8'({4'(ey), 4'(en)}));
    endtask

    initial begin
        #2;
        chk_all_zero("rst");
        @(negedge clk); rst_n = 1'b1;
        tick();
        chk_all_zero("idle");

        session("full8",  16'b0110_1011, 8, 1'b0);   // 1,1,0,1,0,1,1,0 (LSB first)
        session("close4", 16'b0101, 4, 1'b0);        // 1,0,1,0 then close
        session("empty",  16'h0, 0, 1'b0);
        session("cwl",    16'b100, 3, 1'b1);         // 0,0,1 with close on the yes

        // Reset mid-COLLECT after 3 ballots.
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ballot_valid = 1'b1; ballot_g = 1'b1; tick();
        end
        ballot_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_all_zero("midrst");
        @(negedge clk); rst_n = 1'b1;
        session("afterrst", 16'b1, 1, 1'b1);

        for (int s = 0; s < 20; s++) begin
            logic [15:0] b = 16'($urandom);
            int n = $urandom_range(0, VOTERS);
            session($sformatf("rnd%0d", s), b, n, bit'($urandom_range(0, 1)));
        end

`ifdef VOTE_TALLY_TIMEOUT_EN
        // 1 yes ballot, then 16 idle cycles close the session automatically.
        start = 1'b1; tick(); start = 1'b0;
        ballot_valid = 1'b1; ballot_g = 1'b1; tick(); ballot_valid = 1'b0;
        repeat (15) tick();
        chk("tmo.still_collect", 8'(ballot_ready), 1);
        tick();
        chk("tmo.decide_ready", 8'(ballot_ready), 0);
        chk("tmo.decide_busy",  8'(busy), 1);
        tick();
        chk("tmo.done", 8'(done), 1);
        chk("tmo.flag", 8'(timed_out), 1);
        chk("tmo.yes",  8'(yes_count), 1);
        chk("tmo.no",   8'(no_count), 0);
        chk("tmo.pass", 8'(result_pass), 1);
        start = 1'b1; tick(); start = 1'b0;
        chk("tmo.clear", 8'(timed_out), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
